// File: rtl/max_scan_ctrl.sv
// rtl/max_scan_ctrl.sv - frame max (and with MIN_TRACK_EN, min) scanner around one shared comparator
// MIN_TRACK_EN adds min_val/min_idx tracking with a second compare phase per sample.
module max_scan_ctrl #(
  parameter int WIDTH = 4,
  parameter int COUNT = 8,
  localparam int IDX_W = $clog2(COUNT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] max_val,
`ifdef MIN_TRACK_EN
  output logic [IDX_W-1:0] max_idx,
  output logic [WIDTH-1:0] min_val,
  output logic [IDX_W-1:0] min_idx
`else
  output logic [IDX_W-1:0] max_idx
`endif
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ACCEPT  = 3'd1,
    CMP_MAX = 3'd2,
    CMP_MIN = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sample_q, sample_d;
  logic [WIDTH-1:0] max_q, max_d;
  logic [IDX_W-1:0] max_idx_q, max_idx_d;
  logic [WIDTH-1:0] cmp_x, cmp_y;
  logic             cmp_gt;
  logic             last_sample;

`ifdef MIN_TRACK_EN
  logic [WIDTH-1:0] min_q, min_d;
  logic [IDX_W-1:0] min_idx_q, min_idx_d;
`endif

  assign last_sample = (cnt_q == IDX_W'(COUNT - 1));

  // The single comparator; operands are steered by the compare phase.
  always_comb begin
    cmp_x = sample_q;
    cmp_y = max_q;
`ifdef MIN_TRACK_EN
    if (state_q == CMP_MIN) begin
      cmp_x = min_q;
      cmp_y = sample_q;
    end
`endif
    cmp_gt = (cmp_x > cmp_y);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sample_d  = sample_q;
    max_d     = max_q;
    max_idx_d = max_idx_q;
`ifdef MIN_TRACK_EN
    min_d     = min_q;
    min_idx_d = min_idx_q;
`endif
    in_ready  = (state_q == ACCEPT);
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACCEPT;
          cnt_d   = '0;
        end
      end
      ACCEPT: begin
        if (in_valid) begin
          sample_d = in_data;
          state_d  = CMP_MAX;
        end
      end
      CMP_MAX: begin
        // First sample of a frame seeds the running best; ties keep the earlier index.
        if (cnt_q == '0 || cmp_gt) begin
          max_d     = sample_q;
          max_idx_d = cnt_q;
        end
`ifdef MIN_TRACK_EN
        state_d = CMP_MIN;
`else
        if (last_sample) begin
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + IDX_W'(1);
          state_d = ACCEPT;
        end
`endif
      end
`ifdef MIN_TRACK_EN
      CMP_MIN: begin
        if (cnt_q == '0 || cmp_gt) begin
          min_d     = sample_q;
          min_idx_d = cnt_q;
        end
        if (last_sample) begin
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + IDX_W'(1);
          state_d = ACCEPT;
        end
      end
`endif
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sample_q  <= '0;
      max_q     <= '0;
      max_idx_q <= '0;
`ifdef MIN_TRACK_EN
      min_q     <= '0;
      min_idx_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sample_q  <= sample_d;
      max_q     <= max_d;
      max_idx_q <= max_idx_d;
`ifdef MIN_TRACK_EN
      min_q     <= min_d;
      min_idx_q <= min_idx_d;
`endif
    end
  end

  assign max_val = max_q;
  assign max_idx = max_idx_q;
`ifdef MIN_TRACK_EN
  assign min_val = min_q;
  assign min_idx = min_idx_q;
`endif

endmodule

// File: tb/tb_max_scan_ctrl.sv
// tb/tb_max_scan_ctrl.sv - directed table plus random frames for max_scan_ctrl
// Honours MIN_TRACK_EN to also check min tracking and 3-cycle sample timing.
module tb_max_scan_ctrl;
  localparam int WIDTH = 4;
  localparam int COUNT = 8;
  localparam int IDX_W = $clog2(COUNT);
`ifdef MIN_TRACK_EN
  localparam int CPS = 3;
`else
  localparam int CPS = 2;
`endif

  typedef logic [COUNT-1:0][WIDTH-1:0] frame_t;
  typedef struct {
    string  name;
    frame_t s;
    int     emax;
    int     eidx;
    int     gap_at;
    int     gap_len;
    bit     mid_start;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_ready, busy, done;
  logic [WIDTH-1:0] max_val;
  logic [IDX_W-1:0] max_idx;
`ifdef MIN_TRACK_EN
  logic [WIDTH-1:0] min_val;
  logic [IDX_W-1:0] min_idx;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cnt = 0;
  int last_max = 0;
  int last_idx = 0;

  max_scan_ctrl #(.WIDTH(WIDTH), .COUNT(COUNT)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .busy(busy), .done(done), .max_val(max_val),
`ifdef MIN_TRACK_EN
    .max_idx(max_idx), .min_val(min_val), .min_idx(min_idx)
`else
    .max_idx(max_idx)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference: find the extreme value, then the first position holding it.
  function automatic void model(input frame_t s, output int mx, output int mi,
                                output int mn, output int ni);
    int vals[COUNT];
    for (int i = 0; i < COUNT; i++) vals[i] = int'(s[i]);
    mx = vals[0];
    mn = vals[0];
    foreach (vals[i]) begin
      if (vals[i] > mx) mx = vals[i];
      if (vals[i] < mn) mn = vals[i];
    end
    mi = -1;
    ni = -1;
    foreach (vals[i]) begin
      if (mi < 0 && vals[i] == mx) mi = i;
      if (ni < 0 && vals[i] == mn) ni = i;
    end
  endfunction

  task automatic run_frame(input string name, input frame_t s, input int emax, input int eidx,
                           input int gap_at, input int gap_len, input bit mid_start);
    int t0, w, d0, mx, mi, mn, ni;
    bit ready_in_cmp;
    model(s, mx, mi, mn, ni);
    ready_in_cmp = 1'b0;
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    chk({name, "_busy"}, busy, 1);
    chk({name, "_held_max"}, max_val, last_max);
    chk({name, "_held_idx"}, max_idx, last_idx);
    for (int i = 0; i < COUNT; i++) begin
      if (i == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          start = mid_start && (g == 1);
          @(negedge clk);
        end
        start = 1'b0;
      end
      in_valid = 1'b1;
      in_data = s[i];
      w = 0;
      while (!in_ready && w < 20) begin
        @(negedge clk);
        w++;
      end
      if (!in_ready) chk({name, "_ready_timeout"}, 0, 1);
      @(negedge clk);
      in_valid = 1'b0;
      in_data = WIDTH'($urandom);
      if (in_ready) ready_in_cmp = 1'b1;
    end
    w = 0;
    while (!done && w < 10) begin
      @(negedge clk);
      w++;
    end
    chk({name, "_done_seen"}, done, 1);
    chk({name, "_ready_in_cmp_done"}, ready_in_cmp || (done && in_ready), 0);
    if (gap_len == 0) chk({name, "_latency"}, cyc - t0, 1 + COUNT * CPS);
    chk({name, "_max_val"}, max_val, emax);
    chk({name, "_max_idx"}, max_idx, eidx);
`ifdef MIN_TRACK_EN
    chk({name, "_min_val"}, min_val, mn);
    chk({name, "_min_idx"}, min_idx, ni);
`endif
    @(negedge clk);
    chk({name, "_done_one_cycle"}, done, 0);
    chk({name, "_idle_busy"}, busy, 0);
    chk({name, "_done_count"}, done_cnt - d0, 1);
    last_max = emax;
    last_idx = eidx;
  endtask

  vec_t vecs[5];

  initial begin
    frame_t rs;
    int mx, mi, mn, ni, d0;

    vecs[0] = '{"t1", 32'h50179293, 9, 1, -1, 0, 1'b0};
    vecs[1] = '{"t2", 32'h66666666, 6, 0, -1, 0, 1'b0};
    vecs[2] = '{"t3a", 32'hFEDCBA98, 15, 7, -1, 0, 1'b0};
    vecs[3] = '{"t3b", 32'h0000000F, 15, 0, -1, 0, 1'b0};
    vecs[4] = '{"t4", 32'h50179293, 9, 1, 2, 5, 1'b1};

    #12;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_max_val", max_val, 0);
    chk("rst_max_idx", max_idx, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    @(negedge clk);
    chk("idle_ignores_valid", in_ready, 0);
    in_valid = 1'b0;

    for (int v = 0; v < 5; v++)
      run_frame(vecs[v].name, vecs[v].s, vecs[v].emax, vecs[v].eidx,
                vecs[v].gap_at, vecs[v].gap_len, vecs[v].mid_start);

    // Reset mid-frame after the third accepted sample: outputs clear without a clock edge.
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data = WIDTH'(4'hF);
      for (int w = 0; w < 10 && !in_ready; w++) @(negedge clk);
      @(negedge clk);
      in_valid = 1'b0;
    end
    #2 rst = 1'b1;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_in_ready", in_ready, 0);
    chk("t5_done", done, 0);
    chk("t5_max_val", max_val, 0);
    chk("t5_max_idx", max_idx, 0);
`ifdef MIN_TRACK_EN
    chk("t5_min_val", min_val, 0);
    chk("t5_min_idx", min_idx, 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t5_no_done", done_cnt - d0, 0);
    last_max = 0;
    last_idx = 0;
    run_frame("t5_after", 32'h50179293, 9, 1, -1, 0, 1'b0);

    for (int r = 0; r < 24; r++) begin
      for (int i = 0; i < COUNT; i++)
        rs[i] = (r % 3 == 0) ? WIDTH'($urandom_range(0, 3)) : WIDTH'($urandom_range(0, 15));
      model(rs, mx, mi, mn, ni);
      run_frame($sformatf("rnd%0d", r), rs, mx, mi,
                (r % 2 == 0) ? -1 : int'($urandom_range(0, COUNT - 1)),
                (r % 2 == 0) ? 0 : int'($urandom_range(1, 4)), bit'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d required=%0d", cyc, 0);
    $fatal(1, "timeout");
  end
endmodule
